// File: rtl/led_fader_if.sv
// LED bus between the counter stage and the fader: active-low request pattern in,
// active-low PWM drive out.
interface led_fader_if;
  logic [5:0] in_led;
  logic [5:0] out_led;

  modport master (
    output in_led,
    input  out_led
  );

  modport slave (
    input  in_led,
    output out_led
  );
endinterface

// File: rtl/led_fader.sv
// Per-LED PWM fader: each of six LEDs ramps its brightness level toward the requested
// on/off state one STEP per ramp tick, and a shared PWM counter turns level into duty.
module led_fader #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_TIME = 4096,
  parameter int STEP      = 1
) (
  input  logic       in_clk,
  input  logic       in_rst,
  led_fader_if.slave led_bus
);

  localparam int NUM_LEDS = 6;
  localparam int RAMP_W   = $clog2(RAMP_TIME + 1);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_LAST    = LEVEL_MAX - PWM_BITS'(1'b1);
  localparam logic [PWM_BITS:0]   STEP_WIDE   = (PWM_BITS + 1)'(STEP);
  localparam logic [PWM_BITS-1:0] STEP_NARROW = PWM_BITS'(STEP);
  localparam logic [RAMP_W-1:0]   RAMP_LAST   = RAMP_W'(RAMP_TIME - 1);

  logic [NUM_LEDS-1:0]               target_q, target_d;
  logic [RAMP_W-1:0]                 ramp_cnt_q, ramp_cnt_d;
  logic [PWM_BITS-1:0]               pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] level_q, level_d;
  logic [NUM_LEDS-1:0][PWM_BITS:0]   sum_s;
  logic [NUM_LEDS-1:0]               out_q, out_d;
  logic                              tick_s;

  // Ramp tick generator and free-running PWM period counter.
  always_comb begin
    tick_s     = (ramp_cnt_q == RAMP_LAST);
    ramp_cnt_d = ramp_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    if (tick_s) begin
      ramp_cnt_d = '0;
    end else begin
      ramp_cnt_d = ramp_cnt_q + RAMP_W'(1'b1);
    end
    if (pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1'b1);
    end
  end

  // Level stepping: the add is one bit wider so the clamp to LEVEL_MAX is exact,
  // and the subtract is guarded so a partial final step lands on zero.
  always_comb begin
    target_d = ~led_bus.in_led;
    level_d  = level_q;
    sum_s    = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      sum_s[i] = {1'b0, level_q[i]} + STEP_WIDE;
      if (tick_s && target_q[i] && (level_q[i] != LEVEL_MAX)) begin
        if (sum_s[i] > {1'b0, LEVEL_MAX}) begin
          level_d[i] = LEVEL_MAX;
        end else begin
          level_d[i] = sum_s[i][PWM_BITS-1:0];
        end
      end else if (tick_s && !target_q[i] && (level_q[i] != '0)) begin
        if (level_q[i] >= STEP_NARROW) begin
          level_d[i] = level_q[i] - STEP_NARROW;
        end else begin
          level_d[i] = '0;
        end
      end else begin
        level_d[i] = level_q[i];
      end
    end
  end

  // PWM compare; the drive is active-low so a lit LED outputs 0.
  always_comb begin
    out_d = '1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (pwm_cnt_q < level_q[i]) begin
        out_d[i] = 1'b0;
      end else begin
        out_d[i] = 1'b1;
      end
    end
  end

  // State registers; reset blanks the LEDs immediately and abandons any fade.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      target_q   <= '0;
      ramp_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      level_q    <= '0;
      out_q      <= '1;
    end else begin
      target_q   <= target_d;
      ramp_cnt_q <= ramp_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      level_q    <= level_d;
      out_q      <= out_d;
    end
  end

  assign led_bus.out_led = out_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: three instances (STEP=1, STEP=4, slow ramp for duty
// measurement) share clock and reset; expectations are hand-timed from release.
module tb_led_fader;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   low_cnt      = 0;

  led_fader_if bus_a ();
  led_fader_if bus_b ();
  led_fader_if bus_c ();

  led_fader #(.PWM_BITS(4), .RAMP_TIME(4), .STEP(1)) dut_a (
    .in_clk (clk),
    .in_rst (rst_n),
    .led_bus(bus_a.slave)
  );

  led_fader #(.PWM_BITS(4), .RAMP_TIME(4), .STEP(4)) dut_b (
    .in_clk (clk),
    .in_rst (rst_n),
    .led_bus(bus_b.slave)
  );

  led_fader #(.PWM_BITS(4), .RAMP_TIME(64), .STEP(1)) dut_c (
    .in_clk (clk),
    .in_rst (rst_n),
    .led_bus(bus_c.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_off(input string tag);
    check_eq({tag, "_a"}, 32'(bus_a.out_led), 32'h3F);
    check_eq({tag, "_b"}, 32'(bus_b.out_led), 32'h3F);
    check_eq({tag, "_c"}, 32'(bus_c.out_led), 32'h3F);
    check_eq({tag, "_lvl_a"}, 32'(dut_a.level_q[0]), 32'd0);
  endtask

  initial begin
    bus_a.in_led = 6'h00;
    bus_b.in_led = 6'h00;
    bus_c.in_led = 6'h00;

    // Reset held with clock running and arbitrary requests.
    #2 rst_n = 1'b0;
    #1 check_all_off("rst_async");
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      bus_a.in_led = 6'(i * 7);
      bus_b.in_led = 6'(i * 5);
      bus_c.in_led = 6'(i * 3);
      check_all_off($sformatf("rst_hold%0d", i));
    end

    // Release with everything requested off: outputs stay dark.
    bus_a.in_led = 6'h3F;
    bus_b.in_led = 6'h3F;
    bus_c.in_led = 6'h3F;
    rst_n = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      cyc(1);
      check_eq($sformatf("idle_a%0d", i), 32'(bus_a.out_led), 32'h3F);
    end
    check_eq("idle_lvl_a", 32'(dut_a.level_q[0]), 32'd0);

    // Realign all counters with a reset pulse, then fade LED0 in on all instances.
    rst_n = 1'b0;
    #1 check_all_off("realign");
    bus_a.in_led = 6'b111110;
    bus_b.in_led = 6'b111110;
    bus_c.in_led = 6'b111110;
    cyc(1);
    rst_n = 1'b1;
    for (int n = 1; n <= 984; n++) begin
      cyc(1);
      if (n == 3)   check_eq("in_a3",   32'(dut_a.level_q[0]), 32'd0);
      if (n == 4)   check_eq("in_a4",   32'(dut_a.level_q[0]), 32'd1);
      if (n == 20)  check_eq("in_a20",  32'(dut_a.level_q[0]), 32'd5);
      if (n == 40)  check_eq("in_a40",  32'(dut_a.level_q[0]), 32'd10);
      if (n == 60)  check_eq("in_a60",  32'(dut_a.level_q[0]), 32'd15);
      if (n == 100) check_eq("in_a100", 32'(dut_a.level_q[0]), 32'd15);
      if (n >= 62 && n <= 76)
        check_eq($sformatf("full_on_a%0d", n), 32'(bus_a.out_led[0]), 32'd0);
      if (n == 30 || n == 500)
        check_eq($sformatf("in_hi_a%0d", n), 32'(bus_a.out_led[5:1]), 32'h1F);
      if (n == 3)  check_eq("in_b3",  32'(dut_b.level_q[0]), 32'd0);
      if (n == 4)  check_eq("in_b4",  32'(dut_b.level_q[0]), 32'd4);
      if (n == 8)  check_eq("in_b8",  32'(dut_b.level_q[0]), 32'd8);
      if (n == 12) check_eq("in_b12", 32'(dut_b.level_q[0]), 32'd12);
      if (n == 16) check_eq("in_b16", 32'(dut_b.level_q[0]), 32'd15);
      if (n == 24) check_eq("in_b24", 32'(dut_b.level_q[0]), 32'd15);
      // Slow instance holds level k for 64 clocks; any 15 consecutive clocks show k lit.
      if (n % 64 == 10) low_cnt = 0;
      if (n % 64 >= 10 && n % 64 <= 24 && bus_c.out_led[0] == 1'b0) low_cnt++;
      if (n % 64 == 24) begin
        check_eq($sformatf("duty_c_lvl%0d", n / 64), 32'(low_cnt), 32'(n / 64));
        check_eq($sformatf("duty_c_hi%0d", n / 64), 32'(bus_c.out_led[5:1]), 32'h1F);
      end
    end

    // Fade out from full brightness.
    bus_a.in_led = 6'h3F;
    bus_b.in_led = 6'h3F;
    for (int r = 1; r <= 80; r++) begin
      cyc(1);
      if (r == 3)  check_eq("out_a3",  32'(dut_a.level_q[0]), 32'd15);
      if (r == 4)  check_eq("out_a4",  32'(dut_a.level_q[0]), 32'd14);
      if (r == 32) check_eq("out_a32", 32'(dut_a.level_q[0]), 32'd7);
      if (r == 60) check_eq("out_a60", 32'(dut_a.level_q[0]), 32'd0);
      if (r == 80) check_eq("out_a80", 32'(dut_a.level_q[0]), 32'd0);
      if (r >= 62 && r <= 76)
        check_eq($sformatf("full_off_a%0d", r), 32'(bus_a.out_led[0]), 32'd1);
      if (r == 4)  check_eq("out_b4",  32'(dut_b.level_q[0]), 32'd11);
      if (r == 8)  check_eq("out_b8",  32'(dut_b.level_q[0]), 32'd7);
      if (r == 12) check_eq("out_b12", 32'(dut_b.level_q[0]), 32'd3);
      if (r == 16) check_eq("out_b16", 32'(dut_b.level_q[0]), 32'd0);
      if (r == 24) check_eq("out_b24", 32'(dut_b.level_q[0]), 32'd0);
    end

    // Reversal mid-ramp in both directions.
    bus_a.in_led = 6'b111110;
    for (int r = 1; r <= 52; r++) begin
      cyc(1);
      if (r == 28) begin
        check_eq("rev_a28", 32'(dut_a.level_q[0]), 32'd7);
        bus_a.in_led = 6'h3F;
      end
      if (r == 32) check_eq("rev_a32", 32'(dut_a.level_q[0]), 32'd6);
      if (r == 36) begin
        check_eq("rev_a36", 32'(dut_a.level_q[0]), 32'd5);
        bus_a.in_led = 6'b111110;
      end
      if (r == 40) check_eq("rev_a40", 32'(dut_a.level_q[0]), 32'd6);
      if (r == 52) check_eq("rev_a52", 32'(dut_a.level_q[0]), 32'd9);
    end

    // Asynchronous reset between edges at level 9, then a fresh ramp from 0.
    #2 rst_n = 1'b0;
    #1 check_all_off("mid_rst");
    cyc(1);
    rst_n = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      cyc(1);
      if (r == 2) check_eq("rel_out2", 32'(bus_a.out_led), 32'h3F);
      if (r == 3) check_eq("rel_a3", 32'(dut_a.level_q[0]), 32'd0);
      if (r == 4) check_eq("rel_a4", 32'(dut_a.level_q[0]), 32'd1);
      if (r == 8) check_eq("rel_a8", 32'(dut_a.level_q[0]), 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_fader.md
# led_fader

Downstream stage for the LED counter output: takes a 6-bit active-low LED pattern and drives the board LEDs with per-LED PWM brightness. Each LED ramps smoothly toward on or off instead of switching instantly. Sits between the counter's LED bus and the top-level LED pins. It is fully synchronous to the single system clock.

## Interface

- PWM_BITS, default 8: width of the per-LED brightness level and the PWM counter; M = 2^PWM_BITS - 1 is full brightness.
- RAMP_TIME, default 4096: clocks per brightness step; legal values are 1 or more.
- STEP, default 1: brightness change per ramp tick; legal values are 1..M.
- in_clk  input  1  system clock; all state updates on its rising edge.
- in_rst  input  1  reset; asynchronous, active-low.
- in_led  input  6  LED pattern, active-low: bit = 0 requests that LED on.
- out_led  output  6  PWM LED drive, active-low: bit = 0 lights the LED.

## Operation

- Target register: r_target[i] <= ~in_led[i] every clock. All ramp decisions use r_target, never in_led directly.
- Ramp counter:
  - Counts 0..RAMP_TIME-1, then wraps to 0.
  - The tick is asserted on the cycle the counter equals RAMP_TIME-1.
  - With RAMP_TIME=1 the tick is asserted every cycle.
  - Width is $clog2(RAMP_TIME+1) bits.
- Brightness level[i], PWM_BITS wide, range 0..M. Updated only on a tick:
  - r_target[i]=1 and level < M: level <= min(level+STEP, M).
  - r_target[i]=0 and level > 0: level <= max(level-STEP, 0), computed without underflow.
  - Otherwise level holds.
  - The add is computed one bit wider than PWM_BITS so saturation is exact.
- PWM counter:
  - Free-running, shared by all LEDs; counts 0..M-1, then wraps to 0. Period is M clocks.
  - An LED is lit when pwm_cnt < level[i].
  - level=0 gives always off; level=M gives always on; level=k gives exactly k lit clocks per M-clock period.
- Output is registered: out_led[i] <= ~(pwm_cnt < level[i]).
- Target reversal mid-ramp: the level continues from its current value in the new direction. No jump and no restart.
- All six LEDs share the ramp tick and PWM counter. Each LED has independent level and target.

## Timing

- Reset (in_rst=0) forces the following immediately, without waiting for a clock edge:
  - out_led = 6'h3F (all off)
  - all levels = 0
  - r_target = 0
  - ramp counter = 0
  - PWM counter = 0
- Release: the first rising edge with in_rst=1 starts counting. The first tick occurs RAMP_TIME edges after release.
- Input latency:
  - A change on in_led at edge t is visible in r_target after edge t.
  - The first tick at or after edge t+1 applies the change.
  - A tick on the same edge as the in_led change uses the old target.
- Output latency: out_led reflects level and pwm_cnt from the previous clock, one register stage.
- Full fade (0 to M or M to 0) takes ceil(M/STEP) ticks, i.e. ceil(M/STEP)*RAMP_TIME clocks.
- Reset asserted mid-fade abandons the fade entirely. After release, the ramp restarts from level 0.

## Test plan

Use PWM_BITS=4 (M=15), RAMP_TIME=4, STEP=1 unless noted.

- Reset hold: hold in_rst=0 with clock running and any in_led -> out_led=6'h3F throughout. Release with in_led=6'h3F -> out_led stays 6'h3F for 200 clocks.
- Fade in: after release, in_led=6'b111110 -> level[0] steps 0,1,...,15, one step per 4 clocks; it reaches 15 after 15 ticks. In each 15-clock PWM window at level k, out_led[0] is low exactly k clocks. At level 15, out_led[0] is constantly 0. Bits 5:1 stay 1.
- Fade out: from level[0]=15, set in_led=6'h3F -> level[0] decrements to 0 in 15 ticks. out_led[0] is then constantly 1 and never wraps below 0.
- Reversal: at level[0]=7, toggle in_led[0] from 0 to 1 -> the next tick gives level 6 and the following tick gives 5. No discontinuity. Toggle back at 5 -> the next tick gives 6.
- Saturation with STEP=4: ramping up gives levels 0,4,8,12,15 then holds. Ramping down from 15 gives 11,7,3,0 then holds.
- Async reset mid-fade: at level[0]=9, pull in_rst low between clock edges -> out_led=6'h3F before the next edge. After release with in_led[0]=0, level[0] ramps from 0 with the first tick 4 clocks after release.
